// File: rtl/subleq_pkg.sv
// subleq_pkg: shared constants, typedefs and FSM state encoding for the
// SUBLEQ core. The HALT state exists only when SUBLEQ_HALT_EN is defined.
package subleq_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] word_t;

  typedef enum logic [2:0] {
    FETCH_A = 3'd0,
    FETCH_B = 3'd1,
    FETCH_C = 3'd2,
    READ_A  = 3'd3,
    EXEC    = 3'd4
`ifdef SUBLEQ_HALT_EN
    ,
    HALT    = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/subleq_alu.sv
// subleq_alu: combinational subtract plus "less than or equal to zero" flag
// on the two's-complement result (wrapping subtraction).
module subleq_alu
  import subleq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] i_minuend,
  input  logic [DATA_W-1:0] i_subtrahend,
  output logic [DATA_W-1:0] o_difference,
  output logic              o_leq
);

  // Wrapping difference; leq is sign bit or an all-zero result.
  always_comb begin
    o_difference = i_minuend - i_subtrahend;
    o_leq        = o_difference[DATA_W-1] | (o_difference == {DATA_W{1'b0}});
  end

endmodule

// File: rtl/subleq.sv
// subleq: single-instruction (SUBLEQ) core driving an external word-addressed
// memory with a combinational read port and a synchronous write port.
// Five cycles per instruction: FETCH_A, FETCH_B, FETCH_C, READ_A, EXEC.
// Optional macro SUBLEQ_HALT_EN: a taken branch to a negative target (opC
// sign bit set) parks the core in HALT after the EXEC write completes.
module subleq
  import subleq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] addr,
  output logic              writeEnable,
  output logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] readData
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_op_a;
  logic [ADDR_W-1:0] r_op_b;
  logic [DATA_W-1:0] r_op_c;
  logic [DATA_W-1:0] r_val_a;
  logic [DATA_W-1:0] w_diff;
  logic              w_leq;
  logic              w_halt;
  logic [ADDR_W-1:0] w_pc_nxt;

  // The subtraction always sees the live mem[B] word, so A==B gives zero.
  subleq_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .i_minuend   (readData),
    .i_subtrahend(r_val_a),
    .o_difference(w_diff),
    .o_leq       (w_leq)
  );

`ifdef SUBLEQ_HALT_EN
  // Halt when the branch is taken toward a negative target.
  always_comb begin
    w_halt = w_leq & r_op_c[DATA_W-1];
  end
`else
  // Without the halt feature, upper target bits are simply truncated away.
  logic w_unused_op_c;
  always_comb begin
    w_halt        = 1'b0;
    w_unused_op_c = ^r_op_c[DATA_W-1:ADDR_W];
  end
`endif

  // Branch target or fall-through; both wrap modulo the address space.
  always_comb begin
    if (w_leq) begin
      w_pc_nxt = r_op_c[ADDR_W-1:0];
    end else begin
      w_pc_nxt = r_pc + ADDR_W'(3);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FETCH_A;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state sequencing through the fixed five-step instruction.
  always_comb begin
    w_state_nxt = FETCH_A;
    case (r_state)
      FETCH_A: w_state_nxt = FETCH_B;
      FETCH_B: w_state_nxt = FETCH_C;
      FETCH_C: w_state_nxt = READ_A;
      READ_A:  w_state_nxt = EXEC;
`ifdef SUBLEQ_HALT_EN
      EXEC:    w_state_nxt = w_halt ? HALT : FETCH_A;
      HALT:    w_state_nxt = HALT;
`else
      EXEC:    w_state_nxt = FETCH_A;
`endif
      default: w_state_nxt = FETCH_A;
    endcase
  end

  // Memory address mux and write strobe; write data is zero unless writing.
  always_comb begin
    addr        = r_pc;
    writeEnable = 1'b0;
    writeData   = {DATA_W{1'b0}};
    case (r_state)
      FETCH_A: addr = r_pc;
      FETCH_B: addr = r_pc + ADDR_W'(1);
      FETCH_C: addr = r_pc + ADDR_W'(2);
      READ_A:  addr = r_op_a;
      EXEC: begin
        addr        = r_op_b;
        writeEnable = 1'b1;
        writeData   = w_diff;
      end
      default: addr = r_pc;
    endcase
  end

  // Operand capture and program-counter update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= {ADDR_W{1'b0}};
      r_op_a  <= {ADDR_W{1'b0}};
      r_op_b  <= {ADDR_W{1'b0}};
      r_op_c  <= {DATA_W{1'b0}};
      r_val_a <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        FETCH_A: r_op_a  <= readData[ADDR_W-1:0];
        FETCH_B: r_op_b  <= readData[ADDR_W-1:0];
        FETCH_C: r_op_c  <= readData;
        READ_A:  r_val_a <= readData;
        EXEC: begin
          if (!w_halt) begin
            r_pc <= w_pc_nxt;
          end else begin
            r_pc <= r_pc;
          end
        end
        default: r_pc <= r_pc;
      endcase
    end
  end

endmodule

// File: tb/tb_subleq.sv
// tb_subleq: scoreboard bench for the subleq core. A behavioural model runs
// each program on its own copy of memory, queueing the expected writes
// (address, data, following fetch address); a monitor pops and compares them
// whenever the core strobes writeEnable.
module tb_subleq;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int MEM_N = 1024;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] addr;
  logic          writeEnable;
  logic [DW-1:0] writeData;
  logic [DW-1:0] readData;

  logic [DW-1:0] mem     [MEM_N];
  logic [DW-1:0] ref_mem [MEM_N];

  typedef struct {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] nxt;
  } exp_t;

  exp_t          exp_q[$];
  int            ea[$];
  int            n_cmp = 0;
  int            n_err = 0;
  bit            chk_next = 1'b0;
  logic [AW-1:0] exp_next;
  logic [AW-1:0] wr_a;
  logic [DW-1:0] wr_d;

  always #5 clk = ~clk;

  assign readData = mem[addr];

  subleq #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .writeEnable(writeEnable),
    .writeData  (writeData),
    .readData   (readData)
  );

  // External memory write port: capture pre-edge values, commit just after.
  always @(posedge clk) begin
    if (writeEnable) begin
      wr_a = addr;
      wr_d = writeData;
      #1 mem[wr_a] = wr_d;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write must match the head of the queue, and the
  // cycle after it the core must fetch from the expected next address.
  always @(negedge clk) begin
    if (!reset) begin
      chk_next = 1'b0;
    end else begin
      if (chk_next) begin
        chk_next = 1'b0;
        check("next_fetch_addr", 64'(addr), 64'(exp_next));
      end
      if (writeEnable) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: addr %0h data %0h, no write expected", addr, writeData);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("write_addr", 64'(addr), 64'(e.wa));
          check("write_data", 64'(writeData), 64'(e.wd));
          exp_next = e.nxt;
          chk_next = 1'b1;
        end
      end
    end
  end

  // Reference model: execute n SUBLEQ instructions from pc 0 on ref_mem.
  task automatic model(input int n);
    int pc = 0;
    int ia, ib, nxt;
    logic [DW-1:0] a, b, c, d;
    bit leq, halt;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      a  = ref_mem[pc];
      b  = ref_mem[(pc + 1) % MEM_N];
      c  = ref_mem[(pc + 2) % MEM_N];
      ia = int'(a) % MEM_N;
      ib = int'(b) % MEM_N;
      if (ia < 0) ia = ia + MEM_N;
      if (ib < 0) ib = ib + MEM_N;
      d  = ref_mem[ib] - ref_mem[ia];
      ref_mem[ib] = d;
      leq  = ($signed(d) <= 0);
      halt = 1'b0;
`ifdef SUBLEQ_HALT_EN
      halt = leq && c[DW-1];
`endif
      if (halt)     nxt = pc;
      else if (leq) nxt = int'(c[AW-1:0]);
      else          nxt = (pc + 3) % MEM_N;
      e.wa  = AW'(ib);
      e.wd  = d;
      e.nxt = AW'(nxt);
      exp_q.push_back(e);
      if (halt) break;
      pc = nxt;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < MEM_N; i++) begin
      mem[i]     = 32'd0;
      ref_mem[i] = 32'd0;
    end
  endtask

  task automatic poke(input int a, input logic [DW-1:0] d);
    mem[a]     = d;
    ref_mem[a] = d;
  endtask

  // Run n instructions' worth of cycles; check per-cycle addr against ea.
  task automatic run(input int n);
    reset = 1'b0;
    exp_q.delete();
    model(n);
    @(negedge clk);
    reset = 1'b1;
    for (int cyc = 1; cyc <= n * 5 + 1; cyc++) begin
      #2;
      if (cyc <= ea.size()) check("fetch_addr", 64'(addr), 64'(ea[cyc-1]));
      if (cyc <= 5) check("we_first_instr", 64'(writeEnable), 64'(cyc == 5));
      @(negedge clk);
    end
    reset = 1'b0;
    check("pending_writes", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic load_basic(input logic [DW-1:0] v9, input logic [DW-1:0] v10);
    clear_mem();
    poke(0, 32'd9);
    poke(1, 32'd10);
    poke(2, 32'd6);
    poke(9, v9);
    poke(10, v10);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_addr", 64'(addr), 64'd0);
    check("reset_we", 64'(writeEnable), 64'd0);
    check("reset_wdata", 64'(writeData), 64'd0);

    // Not taken: 7-5=2, next pc 3.
    load_basic(32'd5, 32'd7);
    ea.delete();
    ea.push_back(0); ea.push_back(1); ea.push_back(2); ea.push_back(9);
    ea.push_back(10); ea.push_back(3);
    run(3);

    // Zero result: taken to 6.
    load_basic(32'd7, 32'd7);
    ea.delete();
    ea.push_back(0); ea.push_back(1); ea.push_back(2); ea.push_back(9);
    ea.push_back(10); ea.push_back(6);
    run(1);

    // Negative result 3-8: taken to 6.
    load_basic(32'd8, 32'd3);
    run(1);

    // Wrapping subtraction gives a positive value: not taken.
    load_basic(32'h0000_0001, 32'h8000_0000);
    ea.delete();
    ea.push_back(0); ea.push_back(1); ea.push_back(2); ea.push_back(9);
    ea.push_back(10); ea.push_back(3);
    run(1);

    // PC wrap: jump to 1022, fetch 1022/1023/0, fall through to 1.
    clear_mem();
    poke(0, 32'd5);
    poke(1, 32'd5);
    poke(2, 32'd1022);
    poke(1022, 32'd9);
    poke(1023, 32'd10);
    poke(9, 32'd5);
    poke(10, 32'd7);
    ea.delete();
    ea.push_back(0); ea.push_back(1); ea.push_back(2); ea.push_back(5);
    ea.push_back(5); ea.push_back(1022); ea.push_back(1023); ea.push_back(0);
    ea.push_back(9); ea.push_back(10); ea.push_back(1);
    run(2);

    // Reset during READ_A aborts without writing.
    load_basic(32'd5, 32'd7);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("read_a_addr", 64'(addr), 64'd9);
    reset = 1'b0;
    #1;
    check("abort_we", 64'(writeEnable), 64'd0);
    check("abort_addr", 64'(addr), 64'd0);
    check("abort_wdata", 64'(writeData), 64'd0);
    repeat (3) @(negedge clk);
    check("abort_mem_unchanged", 64'(mem[10]), 64'd7);
    ea.delete();
    ea.push_back(0); ea.push_back(1); ea.push_back(2); ea.push_back(9);
    ea.push_back(10); ea.push_back(3);
    run(3);

    // Taken branch to negative target 0xFFFFFFFF.
    clear_mem();
    poke(0, 32'd5);
    poke(1, 32'd5);
    poke(2, 32'hFFFF_FFFF);
    ea.delete();
    ea.push_back(0); ea.push_back(1); ea.push_back(2); ea.push_back(5);
    ea.push_back(5);
`ifdef SUBLEQ_HALT_EN
    for (int k = 0; k < 25; k++) ea.push_back(0);
`else
    ea.push_back(1023);
`endif
    run(6);

    // Random programs, mixing small addresses with full random words.
    for (int t = 0; t < 4; t++) begin
      clear_mem();
      for (int i = 0; i < MEM_N; i++) begin
        if ($urandom_range(0, 1) == 0) poke(i, 32'($urandom_range(0, 63)));
        else poke(i, 32'($urandom));
      end
      ea.delete();
      run(20);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
